// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 access codes,
// FSM state encoding, bus width default and byte-strobe size masks.
package mem_pkg;

    localparam int DEFAULT_BUS_WIDTH = 64;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_RSV = 3'b111;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Access size lives in funct3[1:0]; bit 2 only selects zero-extension.
    function automatic logic [7:0] size_strb(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return STRB_B;
            2'b01:   return STRB_H;
            2'b10:   return STRB_W;
            default: return STRB_D;
        endcase
    endfunction

    function automatic logic [2:0] align_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data extraction: right-justifies the addressed lane of the read
// doubleword and sign- or zero-extends it according to funct3.
module load_extend
    import mem_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
    input  logic [BUS_WIDTH-1:0] rdata,
    input  logic [2:0]           offset,
    input  logic [2:0]           funct3,
    output logic [BUS_WIDTH-1:0] data_out
);

    logic [BUS_WIDTH-1:0] shifted;

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        data_out = '0;
        case (funct3)
            F3_B:    data_out = {{(BUS_WIDTH-8){shifted[7]}},   shifted[7:0]};
            F3_H:    data_out = {{(BUS_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_W:    data_out = {{(BUS_WIDTH-32){shifted[31]}}, shifted[31:0]};
            F3_D:    data_out = shifted;
            F3_BU:   data_out = {{(BUS_WIDTH-8){1'b0}},  shifted[7:0]};
            F3_HU:   data_out = {{(BUS_WIDTH-16){1'b0}}, shifted[15:0]};
            F3_WU:   data_out = {{(BUS_WIDTH-32){1'b0}}, shifted[31:0]};
            default: data_out = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage with a single-outstanding req/ack data port.
// Optional MEM_STAGE_MISALIGN_TRAP_EN adds a misaligned flag instead of forced alignment.
//
//   state | meaning
//   IDLE  | accept an instruction; non-memory ops complete in one cycle
//   REQ   | dmem_req high, request fields held until dmem_ack
//   RESP  | valid_out pulse with extended load data or store address
module mem_stage
    import mem_pkg::*;
#(
    parameter int BUS_WIDTH    = DEFAULT_BUS_WIDTH,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    input  logic [BUS_WIDTH-1:0]    alu_fpu_result,
    input  logic [BUS_WIDTH-1:0]    write_data,
    output logic                    stall,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [BUS_WIDTH-1:0]    dmem_addr,
    output logic [BUS_WIDTH-1:0]    dmem_wdata,
    output logic [BUS_WIDTH/8-1:0]  dmem_wstrb,
    input  logic                    dmem_ack,
    input  logic [BUS_WIDTH-1:0]    dmem_rdata,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    output logic                    misaligned,
`endif
    output logic [BUS_WIDTH-1:0]    result_out,
    output logic                    valid_out
);

    mem_state_e                state_q, state_d;
    logic [BUS_WIDTH-1:0]      addr_q, addr_d;
    logic [FUNCT3_WIDTH-1:0]   f3_q, f3_d;
    logic                      we_q, we_d;
    logic [BUS_WIDTH-1:0]      daddr_q, daddr_d;
    logic [BUS_WIDTH-1:0]      wdata_q, wdata_d;
    logic [BUS_WIDTH/8-1:0]    wstrb_q, wstrb_d;
    logic [BUS_WIDTH-1:0]      result_q, result_d;
    logic                      valid_q, valid_d;
    logic                      misal_q, misal_d;

    logic                      mem_op;
    logic                      is_store;
    logic                      addr_misaligned;
    logic [2:0]                in_off;
    logic [2:0]                ld_off;
    logic [BUS_WIDTH-1:0]      load_data;

    assign mem_op          = mem_read | mem_write;
    assign is_store        = mem_write & ~mem_read;
    assign addr_misaligned = (alu_fpu_result[2:0] & align_mask(funct3)) != 3'b000;
    // Forced natural alignment: drop offset bits below the access size.
    assign in_off          = alu_fpu_result[2:0] & ~align_mask(funct3);
    assign ld_off          = addr_q[2:0] & ~align_mask(f3_q);

    load_extend #(.BUS_WIDTH(BUS_WIDTH)) u_load_extend (
        .rdata    (dmem_rdata),
        .offset   (ld_off),
        .funct3   (f3_q),
        .data_out (load_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        f3_d     = f3_q;
        we_d     = we_q;
        daddr_d  = daddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        result_d = result_q;
        valid_d  = 1'b0;
        misal_d  = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!mem_op) begin
                        valid_d  = 1'b1;
                        result_d = alu_fpu_result;
                    end else if (funct3 == F3_RSV) begin
                        valid_d  = 1'b1;
                        result_d = '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                    end else if (addr_misaligned) begin
                        valid_d  = 1'b1;
                        misal_d  = 1'b1;
                        result_d = alu_fpu_result;
`endif
                    end else begin
                        stall   = 1'b1;
                        state_d = REQ;
                        addr_d  = alu_fpu_result;
                        f3_d    = funct3;
                        we_d    = is_store;
                        daddr_d = {alu_fpu_result[BUS_WIDTH-1:3], 3'b000};
                        wstrb_d = is_store ? (size_strb(funct3) << in_off) : '0;
                        wdata_d = is_store ? (write_data << {in_off, 3'b000}) : '0;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    state_d  = RESP;
                    valid_d  = 1'b1;
                    result_d = we_q ? addr_q : load_data;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            daddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            misal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            we_q     <= we_d;
            daddr_q  <= daddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            misal_q  <= misal_d;
        end
    end

    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign result_out = result_q;
    assign valid_out  = valid_q;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misaligned = misal_q;
`else
    logic unused_misal;
    assign unused_misal = misal_q ^ addr_misaligned;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [63:0] alu_fpu_result;
    logic [63:0] write_data;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic [63:0] result_out;
    logic        valid_out;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .alu_fpu_result (alu_fpu_result),
        .write_data     (write_data),
        .stall          (stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        .misaligned     (misaligned),
`endif
        .result_out     (result_out),
        .valid_out      (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        funct3         = 3'b000;
        alu_fpu_result = '0;
        write_data     = '0;
        dmem_ack       = 1'b0;
        dmem_rdata     = '0;
    endtask

    // One memory transaction: present the op, follow it through REQ with
    // 'waits' extra cycles before the ack, and check the RESP pulse.
    task automatic mem_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] rdata,
                          input int waits, input logic [63:0] exp_daddr,
                          input logic exp_we, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_res);
        valid_in       = 1'b1;
        mem_read       = rd;
        mem_write      = wr;
        funct3         = f3;
        alu_fpu_result = addr;
        write_data     = wd;
        #1;
        check_eq({tag, " stall_accept"}, 64'(stall), 64'd1);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check_eq({tag, " req"},   64'(dmem_req), 64'd1);
            check_eq({tag, " stall"}, 64'(stall), 64'd1);
            check_eq({tag, " addr"},  dmem_addr, exp_daddr);
            check_eq({tag, " vout_wait"}, 64'(valid_out), 64'd0);
        end
        check_eq({tag, " we"},    64'(dmem_we), 64'(exp_we));
        check_eq({tag, " wstrb"}, 64'(dmem_wstrb), 64'(exp_strb));
        check_eq({tag, " wdata"}, dmem_wdata, exp_wdata);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        check_eq({tag, " vout"},   64'(valid_out), 64'd1);
        check_eq({tag, " result"}, result_out, exp_res);
        check_eq({tag, " stall_resp"}, 64'(stall), 64'd0);
        check_eq({tag, " req_resp"},   64'(dmem_req), 64'd0);
        valid_in = 1'b0;
        @(negedge clk);
        check_eq({tag, " vout_once"}, 64'(valid_out), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst valid_out", 64'(valid_out), 64'd0);
        check_eq("rst dmem_req",  64'(dmem_req), 64'd0);
        check_eq("rst dmem_we",   64'(dmem_we), 64'd0);
        check_eq("rst wstrb",     64'(dmem_wstrb), 64'd0);
        check_eq("rst addr",      dmem_addr, 64'd0);
        check_eq("rst wdata",     dmem_wdata, 64'd0);
        check_eq("rst result",    result_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Non-memory pass-through, back to back.
        valid_in = 1'b1;
        alu_fpu_result = 64'hDEAD_BEEF;
        #1;
        check_eq("alu stall", 64'(stall), 64'd0);
        @(negedge clk);
        check_eq("alu vout", 64'(valid_out), 64'd1);
        check_eq("alu result", result_out, 64'hDEAD_BEEF);
        alu_fpu_result = 64'h0123_0000_0000_4567;
        #1;
        check_eq("alu2 stall", 64'(stall), 64'd0);
        @(negedge clk);
        check_eq("alu2 vout", 64'(valid_out), 64'd1);
        check_eq("alu2 result", result_out, 64'h0123_0000_0000_4567);
        valid_in = 1'b0;
        @(negedge clk);
        check_eq("alu vout_drop", 64'(valid_out), 64'd0);

        mem_op("lb", 1'b1, 1'b0, F3_B, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0,
               64'h1000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op("lbu", 1'b1, 1'b0, F3_BU, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0,
               64'h1000, 1'b0, 8'h00, 64'h0, 64'h80);
        mem_op("sw", 1'b0, 1'b1, F3_W, 64'h2004, 64'h1122_3344, 64'h0, 0,
               64'h2000, 1'b1, 8'hF0, 64'h1122_3344_0000_0000, 64'h2004);
        mem_op("ld_wait", 1'b1, 1'b0, F3_D, 64'h1008, 64'h0, 64'h0123_4567_89AB_CDEF, 3,
               64'h1008, 1'b0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
        mem_op("lw", 1'b1, 1'b0, F3_W, 64'h4004, 64'h0, 64'h8765_4321_0000_0000, 1,
               64'h4000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321);
        mem_op("lwu", 1'b1, 1'b0, F3_WU, 64'h4004, 64'h0, 64'h8765_4321_0000_0000, 0,
               64'h4000, 1'b0, 8'h00, 64'h0, 64'h8765_4321);
        mem_op("lhu", 1'b1, 1'b0, F3_HU, 64'h5006, 64'h0, 64'hC3A5_0000_0000_0000, 0,
               64'h5000, 1'b0, 8'h00, 64'h0, 64'hC3A5);
        mem_op("sb", 1'b0, 1'b1, F3_B, 64'h6007, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0, 0,
               64'h6000, 1'b1, 8'h80, 64'h5A00_0000_0000_0000, 64'h6007);
        mem_op("sd", 1'b0, 1'b1, F3_D, 64'h7010, 64'hCAFE_F00D_1234_5678, 64'h0, 2,
               64'h7010, 1'b1, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h7010);
        mem_op("rdwr", 1'b1, 1'b1, F3_B, 64'h8001, 64'h55AA, 64'h0000_0000_0000_7F00, 0,
               64'h8000, 1'b0, 8'h00, 64'h0, 64'h7F);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = F3_H; alu_fpu_result = 64'h3001;
        #1;
        check_eq("trap stall", 64'(stall), 64'd0);
        @(negedge clk);
        check_eq("trap req", 64'(dmem_req), 64'd0);
        check_eq("trap vout", 64'(valid_out), 64'd1);
        check_eq("trap flag", 64'(misaligned), 64'd1);
        check_eq("trap result", result_out, 64'h3001);
        valid_in = 1'b0;
        @(negedge clk);
        check_eq("trap flag_drop", 64'(misaligned), 64'd0);
        check_eq("trap req_after", 64'(dmem_req), 64'd0);
`else
        mem_op("lh_mis", 1'b1, 1'b0, F3_H, 64'h3001, 64'h0, 64'h0000_0000_0000_F234, 0,
               64'h3000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_F234);
        mem_op("sh_mis", 1'b0, 1'b1, F3_H, 64'h3001, 64'hABCD, 64'h0, 0,
               64'h3000, 1'b1, 8'h03, 64'hABCD, 64'h3001);
`endif

        // Reserved funct3 with a memory op: one-cycle zero result, no request.
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = F3_RSV; alu_fpu_result = 64'h9000;
        #1;
        check_eq("rsv stall", 64'(stall), 64'd0);
        @(negedge clk);
        check_eq("rsv req", 64'(dmem_req), 64'd0);
        check_eq("rsv vout", 64'(valid_out), 64'd1);
        check_eq("rsv result", result_out, 64'h0);
        valid_in = 1'b0;
        @(negedge clk);

        // Reset in REQ, then a stray ack in IDLE.
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = F3_D; alu_fpu_result = 64'hA000;
        @(negedge clk);
        check_eq("rstmid req", 64'(dmem_req), 64'd1);
        rst = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        check_eq("rstmid req_drop", 64'(dmem_req), 64'd0);
        check_eq("rstmid vout", 64'(valid_out), 64'd0);
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 64'h1234;
        @(negedge clk);
        check_eq("stray vout", 64'(valid_out), 64'd0);
        check_eq("stray req", 64'(dmem_req), 64'd0);
        dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("stray vout2", 64'(valid_out), 64'd0);
        check_eq("stray result", result_out, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage that consumes the execute-stage result (`alu_fpu_result`) as a load/store address or as a pass-through value.
- Drives a single-outstanding req/ack data-memory port.
- Aligns store data with byte strobes and sign- or zero-extends load data.
- Stalls the upstream pipeline while a transaction is in flight.

Parameters:
- BUS_WIDTH, 64, data/address width; 64 is the only supported value.
- FUNCT3_WIDTH, 3, width of the access-size/sign field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream presents an instruction this cycle.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU, 111 reserved.
- alu_fpu_result  in  64  execute result; used as the byte address for memory operations.
- write_data  in  64  store source (rs2); the low bytes are used.
- stall  out  1  combinational; upstream must hold its inputs while high.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  64  doubleword-aligned address ({addr[63:3], 3'b0}).
- dmem_wdata  out  64  store data shifted to the byte lane.
- dmem_wstrb  out  8  byte enables.
- dmem_ack  in  1  memory completes the transaction this cycle; rdata valid with it.
- dmem_rdata  in  64  read doubleword.
- result_out  out  64  value forwarded to writeback.
- valid_out  out  1  result_out is valid; pulses for exactly one cycle per instruction.

Behaviour:
- FSM states: IDLE, REQ, RESP.
- Reset values: state=IDLE; valid_out, dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, result_out all 0.
- IDLE, valid_in with neither mem_read nor mem_write:
  - result_out <= alu_fpu_result and valid_out <= 1 on the next edge.
  - Latency 1; stall stays 0.
- IDLE, valid_in with mem_read or mem_write:
  - Capture address, funct3, write_data and the op; go to REQ.
  - stall=1 combinationally in this cycle.
- REQ:
  - dmem_req=1; dmem_we, dmem_addr, dmem_wdata, dmem_wstrb held stable until ack.
  - stall=1.
  - On dmem_ack: capture dmem_rdata and go to RESP.
  - Wait states are unbounded.
- RESP:
  - valid_out=1 for one cycle; stall=0; return to IDLE.
  - Load: result_out = extended data. Store: result_out = address.
  - Latency for an ack in the first REQ cycle: valid_out 2 cycles after acceptance, plus 1 per wait cycle.
- Store lane rules, with off = addr[2:0]:
  - wstrb = size mask (0x01/0x03/0x0F/0xFF) << off.
  - wdata = write_data << (8*off).
- Load rule: shift dmem_rdata right by 8*off, then extend per funct3 to 64 bits.
  - LB/LH/LW sign-extend.
  - LBU/LHU/LWU zero-extend.
  - LD passes through.
- mem_read and mem_write both high: treated as a load; no write is issued.
- funct3=111 with a memory op: no dmem transaction; result_out=0, valid_out=1 next cycle (1-cycle path).
- Misalignment without the optional feature: offset bits below the access size are masked to 0 (forced natural alignment).
- Reset mid-transaction:
  - rst returns the FSM to IDLE and drops dmem_req on the same edge.
  - An ack arriving in IDLE is ignored.
- While stall=1, valid_in and the other inputs are held by upstream; no second instruction is accepted before RESP.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Adds output `misaligned` (1 bit, reset 0).
  - A memory op whose addr is not naturally aligned to its size issues no dmem transaction.
  - result_out = address, valid_out=1 and misaligned=1 for one cycle, 1-cycle latency.
- Undefined: the port is absent and the forced-alignment masking above applies.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - FSM state encoding.
  - BUS_WIDTH default.
  - Size-mask constants.
- One combinational sub-module, load_extend: inputs rdata, offset and funct3; output is the 64-bit extended value.

Test Plan:
- LB: addr 0x1003, rdata 0x0000_0000_8000_0000 (0x80 in byte 3), ack in first REQ cycle -> dmem_addr 0x1000; result_out 0xFFFF_FFFF_FFFF_FF80 with valid_out 2 cycles after acceptance. Same access as LBU -> result_out 0x80.
- SW: addr 0x2004, write_data 0x1122_3344 -> dmem_we=1, wstrb 0xF0, wdata 0x1122_3344_0000_0000; result_out 0x2004.
- Wait states: load with ack delayed 3 cycles -> req, addr and stall held stable for 4 REQ cycles; valid_out pulses exactly once.
- Non-memory instruction: result 0xDEAD_BEEF -> result_out 0xDEAD_BEEF next cycle; stall never asserted.
- Reset mid-transaction: rst while in REQ -> dmem_req=0 next cycle; a subsequent stray ack produces no valid_out.
- With MEM_STAGE_MISALIGN_TRAP_EN: LH at 0x3001 -> no dmem_req, misaligned=1, result_out 0x3001.
- Without MEM_STAGE_MISALIGN_TRAP_EN: LH at 0x3001 -> wstrb/extraction uses offset 0.
